// File: rtl/root_stream_sequencer.sv
// rtl/root_stream_sequencer.sv - start/busy/done sequencer for the digit-serial MSD-first online square-root datapath
// Optional abort input is compiled in when ROOT_SEQ_ABORT_EN is defined.
// All handshake and datapath-control outputs are registered decodes of the FSM
// state, so each output lags its state by one clock.

module root_stream_sequencer #(
  parameter int N_DIGITS = 8,
  parameter int DELAY    = 1
) (
  input  logic                    i_clk,
  input  logic                    i_Reset,
  input  logic                    i_start,
  input  logic [2*N_DIGITS-1:0]   i_operand,
`ifdef ROOT_SEQ_ABORT_EN
  input  logic                    i_abort,
`endif
  output logic                    o_busy,
  output logic                    o_done,
  output logic [2*N_DIGITS-1:0]   o_result,
  output logic                    o_root_init,
  output logic                    o_root_en,
  output logic [1:0]              o_root_x,
  input  logic [1:0]              i_root_y
);

  localparam int W  = 2 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + DELAY + 1);
  localparam logic [CW-1:0] LAST_TX = CW'(N_DIGITS + DELAY - 1);
  localparam logic [CW-1:0] SKIP_RX = CW'(DELAY);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_operand;
  logic [CW-1:0]   r_tx_cnt;
  logic [CW-1:0]   r_rx_cnt;
  logic            r_en_d;
  logic            r_busy;
  logic            r_done;
  logic            r_root_init;
  logic            r_root_en;
  logic [1:0]      r_root_x;
  logic [W-1:0]    r_result;
  logic            w_abort;
  logic            w_active;

`ifdef ROOT_SEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Abort only has meaning while an operation is actually being sequenced.
  assign w_active = (r_state == S_INIT) || (r_state == S_STREAM) || (r_state == S_DRAIN);

  // Sequencer FSM, operand shifter, and capture of the returned digit stream.
  always_ff @(posedge i_clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= S_IDLE;
      r_operand   <= '0;
      r_tx_cnt    <= '0;
      r_rx_cnt    <= '0;
      r_en_d      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_root_init <= 1'b0;
      r_root_en   <= 1'b0;
      r_root_x    <= 2'b00;
      r_result    <= '0;
    end else begin
      // The datapath registers its output, so a digit is valid one cycle after its enable.
      r_en_d <= r_root_en;
      if (r_en_d) begin
        if (r_rx_cnt >= SKIP_RX) begin
          r_result <= {r_result[W-3:0], i_root_y};
        end
        r_rx_cnt <= r_rx_cnt + ONE;
      end

      case (r_state)
        S_IDLE: begin
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_root_init <= 1'b0;
          r_root_en   <= 1'b0;
          r_root_x    <= 2'b00;
          if (i_start) begin
            r_operand <= i_operand;
            r_state   <= S_INIT;
          end
        end
        S_INIT: begin
          r_busy      <= 1'b1;
          r_root_init <= 1'b1;
          r_result    <= '0;
          r_tx_cnt    <= '0;
          r_rx_cnt    <= '0;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          // Shifting the operand left feeds MSD first and leaves zeros for the flush digits.
          r_root_init <= 1'b0;
          r_root_en   <= 1'b1;
          r_root_x    <= r_operand[W-1:W-2];
          r_operand   <= {r_operand[W-3:0], 2'b00};
          r_tx_cnt    <= r_tx_cnt + ONE;
          if (r_tx_cnt == LAST_TX) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_root_en <= 1'b0;
          r_root_x  <= 2'b00;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Abort overrides the normal transition, including DRAIN -> DONE.
      if (w_abort && w_active) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_root_init <= 1'b0;
        r_root_en   <= 1'b0;
        r_root_x    <= 2'b00;
        r_en_d      <= 1'b0;
        r_result    <= '0;
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_root_init = r_root_init;
  assign o_root_en   = r_root_en;
  assign o_root_x    = r_root_x;

endmodule

// File: tb/tb_root_stream_sequencer.sv
// tb/tb_root_stream_sequencer.sv - self-checking bench for root_stream_sequencer
module tb_root_stream_sequencer;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 if (clk_en) clk = ~clk;

  // default instance: N_DIGITS=8, DELAY=1
  localparam int DA = 1;
  logic        start_a = 1'b0;
  logic [15:0] op_a = '0;
  logic        abort_a = 1'b0;
  logic        busy_a, done_a, init_a, en_a;
  logic [15:0] result_a;
  logic [1:0]  x_a, y_a;
  logic [1:0]  sa [0:DA];

  root_stream_sequencer dut_a (
    .i_clk(clk), .i_Reset(rst), .i_start(start_a), .i_operand(op_a),
`ifdef ROOT_SEQ_ABORT_EN
    .i_abort(abort_a),
`endif
    .o_busy(busy_a), .o_done(done_a), .o_result(result_a),
    .o_root_init(init_a), .o_root_en(en_a), .o_root_x(x_a), .i_root_y(y_a)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DA; i++) sa[i] <= 2'b00;
    end else if (init_a) begin
      for (int i = 0; i <= DA; i++) sa[i] <= 2'b00;
    end else if (en_a) begin
      sa[0] <= x_a;
      for (int i = 1; i <= DA; i++) sa[i] <= sa[i-1];
    end
  end
  assign y_a = sa[DA];

  // second instance: N_DIGITS=4, DELAY=2
  localparam int DB = 2;
  logic        start_b = 1'b0;
  logic [7:0]  op_b = '0;
  logic        abort_b = 1'b0;
  logic        busy_b, done_b, init_b, en_b;
  logic [7:0]  result_b;
  logic [1:0]  x_b, y_b;
  logic [1:0]  sb [0:DB];

  root_stream_sequencer #(.N_DIGITS(4), .DELAY(DB)) dut_b (
    .i_clk(clk), .i_Reset(rst), .i_start(start_b), .i_operand(op_b),
`ifdef ROOT_SEQ_ABORT_EN
    .i_abort(abort_b),
`endif
    .o_busy(busy_b), .o_done(done_b), .o_result(result_b),
    .o_root_init(init_b), .o_root_en(en_b), .o_root_x(x_b), .i_root_y(y_b)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= DB; i++) sb[i] <= 2'b00;
    end else if (init_b) begin
      for (int i = 0; i <= DB; i++) sb[i] <= 2'b00;
    end else if (en_b) begin
      sb[0] <= x_b;
      for (int i = 1; i <= DB; i++) sb[i] <= sb[i-1];
    end
  end
  assign y_b = sb[DB];

  logic [15:0] exp_q [$];
  logic [7:0]  exp_qb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation on dut_a; poke_n >= 0 pulses a stray start (with operand FFFF) at that cycle.
  task automatic run_a(input string tag, input logic [15:0] op, input int poke_n);
    int n, init_cnt, init_n, en_cnt, en_bad, x_bad, busy_cnt, done_n;
    logic [31:0] xacc;
    logic [15:0] exp;
    @(negedge clk);
    op_a = op; start_a = 1'b1; exp_q.push_back(op);
    @(negedge clk);
    start_a = 1'b0;
    n = 0; init_cnt = 0; init_n = -1; en_cnt = 0; en_bad = 0; x_bad = 0;
    busy_cnt = 0; done_n = -1; xacc = '0;
    while (done_n < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == poke_n) begin start_a = 1'b1; op_a = 16'hFFFF; end
      else if (n == poke_n + 1) start_a = 1'b0;
      if (init_a) begin init_cnt++; if (init_n < 0) init_n = n; end
      if (en_a) begin
        en_cnt++; xacc = {xacc[29:0], x_a};
        if (n < 2 || n > 10) en_bad++;
      end else if (x_a !== 2'b00) x_bad++;
      if (busy_a) busy_cnt++;
      if (done_a) done_n = n;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    check({tag, " init_cnt"}, init_cnt, 1);
    check({tag, " init_at"}, init_n, 1);
    check({tag, " en_cnt"}, en_cnt, 9);
    check({tag, " en_window"}, en_bad, 0);
    check({tag, " x_idle_zero"}, x_bad, 0);
    check({tag, " x_seq"}, xacc, {14'd0, op, 2'b00});
    check({tag, " busy_cnt"}, busy_cnt, 12);
    check({tag, " done_latency"}, done_n, 12);
    check({tag, " result"}, result_a, exp);
    @(negedge clk);
    check({tag, " done_pulse"}, done_a, 1'b0);
    check({tag, " busy_after"}, busy_a, 1'b0);
    check({tag, " result_hold"}, result_a, exp);
  endtask

  initial begin
    int n, done1, done2, init2, en_cnt, done_n, seen;
    logic [31:0] xacc;
    logic [15:0] e16;
    logic [7:0]  e8;

    // async reset with the clock stopped
    #2 rst = 1'b1;
    #1;
    check("rst busy", busy_a, 1'b0);
    check("rst done", done_a, 1'b0);
    check("rst init", init_a, 1'b0);
    check("rst en", en_a, 1'b0);
    check("rst x", x_a, 2'b00);
    check("rst result", result_a, 16'h0);
    check("rst b result", result_b, 8'h0);
    clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_a("basic", 16'h4A01, -1);

    // stray start mid-STREAM is ignored and not queued
    run_a("ignore", 16'h4A01, 5);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (init_a || busy_a) seen++;
    end
    check("ignore no_requeue", seen, 0);

    // start held high: back-to-back operations, operand changed after acceptance
    @(negedge clk);
    op_a = 16'h4A01; start_a = 1'b1; exp_q.push_back(16'h4A01);
    @(negedge clk);
    op_a = 16'h5C3E; exp_q.push_back(16'h5C3E);
    n = 0; done1 = -1; done2 = -1; init2 = -1;
    while (done2 < 0 && n < 60) begin
      @(negedge clk);
      n++;
      if (init_a && done1 >= 0 && init2 < 0) begin init2 = n; start_a = 1'b0; end
      if (done_a) begin
        e16 = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
        check("held result", result_a, e16);
        if (done1 < 0) done1 = n; else done2 = n;
      end
    end
    start_a = 1'b0;
    check("held done1", done1, 12);
    check("held init2", init2, 14);
    check("held done2", done2, 25);

    // reset mid-STREAM (stream cycle 4)
    @(negedge clk);
    op_a = 16'h4A01; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("midrst pre_en", en_a, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst en", en_a, 1'b0);
    check("midrst busy", busy_a, 1'b0);
    check("midrst result", result_a, 16'h0);
    check("midrst x", x_a, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    check("midrst no_done", seen, 0);
    run_a("after_rst", 16'h1234, -1);

    // N_DIGITS=4, DELAY=2 instance
    @(negedge clk);
    op_b = 8'hD2; start_b = 1'b1; exp_qb.push_back(8'hD2);
    @(negedge clk);
    start_b = 1'b0; op_b = 8'h00;
    n = 0; en_cnt = 0; done_n = -1; xacc = '0;
    while (done_n < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (en_b) begin en_cnt++; xacc = {xacc[29:0], x_b}; end
      if (done_b) done_n = n;
    end
    e8 = (exp_qb.size() > 0) ? exp_qb.pop_front() : 8'hAD;
    check("p42 en_cnt", en_cnt, 6);
    check("p42 x_seq", xacc, {20'd0, 8'hD2, 4'b0000});
    check("p42 done_latency", done_n, 9);
    check("p42 result", result_b, e8);

`ifdef ROOT_SEQ_ABORT_EN
    @(negedge clk);
    op_a = 16'h4A01; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort en", en_a, 1'b0);
    check("abort busy", busy_a, 1'b0);
    check("abort result", result_a, 16'h0);
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done_a || busy_a) seen++;
    end
    check("abort no_done", seen, 0);
    run_a("after_abort", 16'hB7C5, -1);
`endif

    check("scoreboard empty", exp_q.size() + exp_qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
